// File: rtl/lcd_pkg.sv
// Shared LCD interface constants and the reader state encoding.
package lcd_pkg;

    // Reference clock and derived one-microsecond tick count.
    localparam int LCD_FREQ = 50_000_000;
    localparam int LCD_T1US = LCD_FREQ / 1_000_000;

    // E-strobe timing in microseconds, shared with the LCD write path.
    localparam int LCD_T_SETUP_US = 1;
    localparam int LCD_T_EH_US    = 3;
    localparam int LCD_T_EL_US    = 1;

    // Cycle counts at the reference clock.
    localparam int LCD_T_SETUP = LCD_T_SETUP_US * LCD_T1US;
    localparam int LCD_T_EH    = LCD_T_EH_US * LCD_T1US;
    localparam int LCD_T_EL    = LCD_T_EL_US * LCD_T1US;

    typedef enum logic [2:0] {
        RD_IDLE   = 3'd0,
        RD_SETUP  = 3'd1,
        RD_E_HI   = 3'd2,
        RD_E_LO   = 3'd3,
        RD_FINISH = 3'd4
    } rd_state_e;

    // Largest of three phase lengths; sizes the shared phase counter.
    function automatic int lcd_max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Phase timer: clears on request, counts up to a terminal value and holds there.
module lcd_phase_timer #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic         tc
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next count: clear wins, otherwise advance until the terminal value so it never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != tc_val)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/lcd_reader.sv
// 4-bit LCD read controller: two-nibble byte read with optional busy-flag polling.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   RD_IDLE   | bus released (RW=0, OE=1); waiting for start
//   RD_SETUP  | RS/RW settled, address setup before the E rising edge
//   RD_E_HI   | E high; LCD_D_IN sampled on the last cycle of the phase
//   RD_E_LO   | E low; next nibble, next poll byte, or finish
//   RD_FINISH | one-cycle done pulse, timeout valid; bus released on exit
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int FREQ      = 50_000_000,
    parameter int MAX_POLLS = 2000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic       rs,
    input  logic       poll_busy,
    input  logic [3:0] LCD_D_IN,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic       LCD_D_OE,
    output logic [7:0] read_data,
    output logic       active,
    output logic       done,
    output logic       timeout
);

    localparam int T1US    = FREQ / 1_000_000;
    localparam int T_SETUP = LCD_T_SETUP_US * T1US;
    localparam int T_EH    = LCD_T_EH_US * T1US;
    localparam int T_EL    = LCD_T_EL_US * T1US;
    localparam int T_MAX   = lcd_max3(T_SETUP, T_EH, T_EL);
    localparam int PW      = $clog2(T_MAX + 1);
    localparam int CW      = $clog2(MAX_POLLS + 1);

    // Terminal counts: the counter starts at 0 in the first cycle of a phase.
    localparam logic [PW-1:0] TC_SETUP = PW'(T_SETUP - 1);
    localparam logic [PW-1:0] TC_EH    = PW'(T_EH - 1);
    localparam logic [PW-1:0] TC_EL    = PW'(T_EL - 1);
    localparam logic [CW-1:0] POLL_MAX = CW'(MAX_POLLS);

    rd_state_e state_d, state_q;
    logic          rs_d, rs_q;
    logic          poll_en_d, poll_en_q;
    logic          nib_d, nib_q;
    logic [7:0]    rd_d, rd_q;
    logic [CW-1:0] poll_cnt_d, poll_cnt_q;
    logic          rw_d, rw_q;
    logic          e_d, e_q;
    logic          oe_d, oe_q;
    logic          active_d, active_q;
    logic          done_d, done_q;
    logic          timeout_d, timeout_q;

    logic          ph_clr;
    logic          ph_en;
    logic          ph_tc;
    logic [PW-1:0] ph_tc_val;

    // Phase length for the current state; the counter restarts on every state change.
    always_comb begin
        ph_tc_val = '0;
        case (state_q)
            RD_SETUP: ph_tc_val = TC_SETUP;
            RD_E_HI:  ph_tc_val = TC_EH;
            RD_E_LO:  ph_tc_val = TC_EL;
            default:  ph_tc_val = '0;
        endcase
        ph_clr = (state_d != state_q) || (state_q == RD_IDLE);
        ph_en  = (state_q != RD_IDLE);
    end

    lcd_phase_timer #(
        .W (PW)
    ) u_phase_timer (
        .CLK    (CLK),
        .RST    (RST),
        .clr    (ph_clr),
        .en     (ph_en),
        .tc_val (ph_tc_val),
        .tc     (ph_tc)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        rs_d       = rs_q;
        poll_en_d  = poll_en_q;
        nib_d      = nib_q;
        rd_d       = rd_q;
        poll_cnt_d = poll_cnt_q;
        timeout_d  = 1'b0;

        case (state_q)
            RD_IDLE: begin
                if (start) begin
                    state_d    = RD_SETUP;
                    rs_d       = rs;
                    poll_en_d  = poll_busy;
                    poll_cnt_d = '0;
                    nib_d      = 1'b0;
                end
            end
            RD_SETUP: begin
                if (ph_tc) state_d = RD_E_HI;
            end
            RD_E_HI: begin
                if (ph_tc) begin
                    if (!nib_q) rd_d[7:4] = LCD_D_IN;
                    else        rd_d[3:0] = LCD_D_IN;
                    state_d = RD_E_LO;
                end
            end
            RD_E_LO: begin
                if (ph_tc) begin
                    if (!nib_q) begin
                        nib_d   = 1'b1;
                        state_d = RD_E_HI;
                    end else if (poll_en_q && rd_q[7] && (poll_cnt_q < POLL_MAX)) begin
                        poll_cnt_d = poll_cnt_q + CW'(1);
                        nib_d      = 1'b0;
                        state_d    = RD_SETUP;
                    end else begin
                        // Still busy here means the poll budget is exhausted.
                        timeout_d = poll_en_q && rd_q[7];
                        state_d   = RD_FINISH;
                    end
                end
            end
            RD_FINISH: begin
                state_d = RD_IDLE;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase

        rw_d     = (state_d != RD_IDLE);
        oe_d     = (state_d == RD_IDLE);
        active_d = (state_d != RD_IDLE);
        e_d      = (state_d == RD_E_HI);
        done_d   = (state_d == RD_FINISH);
    end

    // State and output registers; reset aborts any transaction without a done pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= RD_IDLE;
            rs_q       <= 1'b0;
            poll_en_q  <= 1'b0;
            nib_q      <= 1'b0;
            rd_q       <= '0;
            poll_cnt_q <= '0;
            rw_q       <= 1'b0;
            e_q        <= 1'b0;
            oe_q       <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rs_q       <= rs_d;
            poll_en_q  <= poll_en_d;
            nib_q      <= nib_d;
            rd_q       <= rd_d;
            poll_cnt_q <= poll_cnt_d;
            rw_q       <= rw_d;
            e_q        <= e_d;
            oe_q       <= oe_d;
            active_q   <= active_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign LCD_RS    = rs_q;
    assign LCD_RW    = rw_q;
    assign LCD_E     = e_q;
    assign LCD_D_OE  = oe_q;
    assign read_data = rd_q;
    assign active    = active_q;
    assign done      = done_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_lcd_reader.sv
// Directed bench for lcd_reader: default, small-poll-budget and 100 MHz instances.
module tb_lcd_reader;

    logic       CLK = 1'b0;
    logic       RST;
    logic       start;
    logic       rs;
    logic       poll_busy;
    logic [3:0] d_in;
    int         sel;

    logic start_a, start_b, start_c;
    logic rs_a, rw_a, e_a, oe_a, act_a, done_a, tmo_a;
    logic rs_b, rw_b, e_b, oe_b, act_b, done_b, tmo_b;
    logic rs_c, rw_c, e_c, oe_c, act_c, done_c, tmo_c;
    logic [7:0] rd_a, rd_b, rd_c;

    logic m_rs, m_rw, m_e, m_oe, m_act, m_done, m_tmo;
    logic [7:0] m_rd;

    int n_tot = 0;
    int n_bad = 0;

    logic [3:0] feed [0:7];
    int         feed_len;

    int         r_done_cyc, r_ndone, r_rise1, r_rise2, r_np, r_afall;
    logic       r_tmo, r_act_end;
    logic [7:0] r_rd;
    logic [4:0] r_c1;

    always #5 CLK = ~CLK;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    assign m_rs   = (sel == 0) ? rs_a   : (sel == 1) ? rs_b   : rs_c;
    assign m_rw   = (sel == 0) ? rw_a   : (sel == 1) ? rw_b   : rw_c;
    assign m_e    = (sel == 0) ? e_a    : (sel == 1) ? e_b    : e_c;
    assign m_oe   = (sel == 0) ? oe_a   : (sel == 1) ? oe_b   : oe_c;
    assign m_act  = (sel == 0) ? act_a  : (sel == 1) ? act_b  : act_c;
    assign m_done = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
    assign m_tmo  = (sel == 0) ? tmo_a  : (sel == 1) ? tmo_b  : tmo_c;
    assign m_rd   = (sel == 0) ? rd_a   : (sel == 1) ? rd_b   : rd_c;

    lcd_reader dut_a (
        .CLK(CLK), .RST(RST), .start(start_a), .rs(rs), .poll_busy(poll_busy),
        .LCD_D_IN(d_in), .LCD_RS(rs_a), .LCD_RW(rw_a), .LCD_E(e_a), .LCD_D_OE(oe_a),
        .read_data(rd_a), .active(act_a), .done(done_a), .timeout(tmo_a)
    );

    lcd_reader #(.MAX_POLLS(3)) dut_b (
        .CLK(CLK), .RST(RST), .start(start_b), .rs(rs), .poll_busy(poll_busy),
        .LCD_D_IN(d_in), .LCD_RS(rs_b), .LCD_RW(rw_b), .LCD_E(e_b), .LCD_D_OE(oe_b),
        .read_data(rd_b), .active(act_b), .done(done_b), .timeout(tmo_b)
    );

    lcd_reader #(.FREQ(100_000_000)) dut_c (
        .CLK(CLK), .RST(RST), .start(start_c), .rs(rs), .poll_busy(poll_busy),
        .LCD_D_IN(d_in), .LCD_RS(rs_c), .LCD_RW(rw_c), .LCD_E(e_c), .LCD_D_OE(oe_c),
        .read_data(rd_c), .active(act_c), .done(done_c), .timeout(tmo_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One transaction on the selected instance; c counts cycles after the start edge.
    task automatic run_txn(input int budget, input bit retrig);
        int   fidx;
        logic pe, pa;
        fidx = 0;
        d_in = feed[0];
        r_done_cyc = -1; r_ndone = 0; r_rise1 = -1; r_rise2 = -1;
        r_np = 0; r_afall = 0; r_tmo = 1'b0; r_rd = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        r_c1 = {m_act, m_rw, m_oe, m_rs, m_e};
        pe = 1'b0;
        pa = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            if (m_e && !pe) begin
                r_np++;
                if (r_np == 1) r_rise1 = c;
                else if (r_np == 2) r_rise2 = c;
            end
            if (!m_e && pe) begin
                if (fidx < feed_len - 1) fidx++;
                d_in = feed[fidx];
            end
            if (m_done) begin
                r_ndone++;
                if (r_done_cyc < 0) begin
                    r_done_cyc = c;
                    r_tmo = m_tmo;
                    r_rd = m_rd;
                end
                if (retrig) start = 1'b1;
            end
            if (pa && !m_act) r_afall++;
            if (retrig && c == 100) start = 1'b1;
            pe = m_e;
            pa = m_act;
            tick();
            start = 1'b0;
        end
        r_act_end = m_act;
    endtask

    initial begin
        int nbad_idle;
        int nd;
        RST = 1'b1; start = 1'b0; rs = 1'b0; poll_busy = 1'b0; d_in = 4'h0; sel = 0;
        feed_len = 1;
        for (int i = 0; i < 8; i++) feed[i] = 4'h0;
        tick();
        tick();

        // reset state
        chk("rst_rd", rd_a, 8'h00);
        chk("rst_act", act_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_tmo", tmo_a, 1'b0);
        chk("rst_bus", {rs_a, rw_a, e_a, oe_a}, 4'b0001);

        // idle after reset: bus released throughout
        RST = 1'b0;
        nbad_idle = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if ({oe_a, rw_a, e_a} !== 3'b100) nbad_idle++;
        end
        chk("idle_bus", nbad_idle, 0);

        // scenario 1: data RAM read, A then 5
        sel = 0; rs = 1'b1; poll_busy = 1'b0;
        feed[0] = 4'hA; feed[1] = 4'h5; feed_len = 2;
        run_txn(500, 1'b0);
        chk("s1_c1", r_c1, 5'b11010);
        chk("s1_rise1", r_rise1, 51);
        chk("s1_rise2", r_rise2, 251);
        chk("s1_pulses", r_np, 2);
        chk("s1_done_cyc", r_done_cyc, 451);
        chk("s1_ndone", r_ndone, 1);
        chk("s1_rd", r_rd, 8'hA5);
        chk("s1_tmo", r_tmo, 1'b0);
        chk("s1_act_end", {r_act_end, rw_a, oe_a}, 3'b001);

        // scenario 2: busy poll, three busy bytes then ready
        rs = 1'b0; poll_busy = 1'b1;
        feed[0] = 4'h8; feed[1] = 4'h8; feed[2] = 4'h8; feed[3] = 4'h8;
        feed[4] = 4'h8; feed[5] = 4'h8; feed[6] = 4'h0; feed[7] = 4'h0;
        feed_len = 8;
        run_txn(2000, 1'b0);
        chk("s2_c1", r_c1, 5'b11000);
        chk("s2_pulses", r_np, 8);
        chk("s2_done_cyc", r_done_cyc, 1801);
        chk("s2_ndone", r_ndone, 1);
        chk("s2_tmo", r_tmo, 1'b0);
        chk("s2_rd", r_rd, 8'h00);

        // scenario 3: poll budget of 3 exhausted with D held at F
        sel = 1; rs = 1'b0; poll_busy = 1'b1;
        feed[0] = 4'hF; feed_len = 1;
        run_txn(2000, 1'b0);
        chk("s3_ndone", r_ndone, 1);
        chk("s3_tmo", r_tmo, 1'b1);
        chk("s3_rd", r_rd, 8'hFF);

        // scenario 4: start while busy and in the done cycle is ignored
        sel = 0; rs = 1'b1; poll_busy = 1'b0;
        feed[0] = 4'hA; feed[1] = 4'h5; feed_len = 2;
        run_txn(500, 1'b1);
        chk("s4_done_cyc", r_done_cyc, 451);
        chk("s4_ndone", r_ndone, 1);
        chk("s4_afall", r_afall, 1);
        chk("s4_act_end", r_act_end, 1'b0);

        // scenario 5: reset inside the first E-high phase
        d_in = 4'hA;
        start = 1'b1;
        tick();
        start = 1'b0;
        nd = 0;
        for (int c = 1; c < 120; c++) begin
            if (done_a) nd++;
            tick();
        end
        chk("s5_e_before", e_a, 1'b1);
        RST = 1'b1;
        start = 1'b1;
        tick();
        chk("s5_bus_after", {e_a, rw_a, oe_a, act_a}, 4'b0010);
        tick();
        RST = 1'b0;
        start = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (done_a || act_a) nd++;
            tick();
        end
        chk("s5_quiet", nd, 0);
        feed[0] = 4'h3; feed[1] = 4'hC; feed_len = 2;
        run_txn(500, 1'b0);
        chk("s5_done_cyc", r_done_cyc, 451);
        chk("s5_rd", r_rd, 8'h3C);

        // 100 MHz instance: setup 100, E high 300, E low 100
        sel = 2; rs = 1'b1; poll_busy = 1'b0;
        feed[0] = 4'hA; feed[1] = 4'h5; feed_len = 2;
        run_txn(950, 1'b0);
        chk("f100_rise1", r_rise1, 101);
        chk("f100_rise2", r_rise2, 501);
        chk("f100_done_cyc", r_done_cyc, 901);
        chk("f100_rd", r_rd, 8'hA5);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
